// File: rtl/crc_net_pkg.sv
// Shared constants, rx FSM state type and the serial CRC-8 step used by the
// tx and rx sides of the single-wire packet link.
package crc_net_pkg;

    localparam int PKT_W       = 136;
    localparam int CRC_W       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int BIT_CNT_W   = $clog2(PKT_W);

    localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    // One MSB-first CRC-8 step: non-reflected, caller supplies the running value.
    function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                   input logic             bit_in);
        logic fb;
        fb = crc[CRC_W-1] ^ bit_in;
        return (crc << 1) ^ (fb ? CRC_POLY : '0);
    endfunction

endpackage

// File: rtl/rx_receiver_sync.sv
// Multi-flop synchroniser for the asynchronous serial line; resets to the
// idle (high) level so a reset never fabricates a start bit.
import crc_net_pkg::*;

module rx_sync #(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = (sync_q << 1) | STAGES'(d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rx_receiver.sv
// Serial frame receiver: start bit, PKT_W bits MSB first, stop bit, with a
// running CRC-8 over the payload. RX_ERR_COUNT_EN adds a saturating error counter.
import crc_net_pkg::*;

module rx_receiver (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_line,
    output logic [PKT_W-1:0] rx_packet,
    output logic             rx_valid,
    output logic             crc_ok,
    output logic             frame_err,
`ifdef RX_ERR_COUNT_EN
    output logic [7:0]       err_count,
`endif
    output logic             busy
);

    localparam logic [BIT_CNT_W-1:0] DATA_BITS = BIT_CNT_W'(PKT_W - CRC_W);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(PKT_W - 1);

    logic rx_s;

    rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_line),
        .q     (rx_s)
    );

    rx_state_t             state_q,     state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [CRC_W-1:0]      crc_q,       crc_d;
    logic [PKT_W-1:0]      shift_q,     shift_d;
    logic [PKT_W-1:0]      rx_packet_q, rx_packet_d;
    logic                  rx_valid_q,  rx_valid_d;
    logic                  crc_ok_q,    crc_ok_d;
    logic                  frame_err_q, frame_err_d;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        crc_d       = crc_q;
        shift_d     = shift_q;
        rx_packet_d = rx_packet_q;
        crc_ok_d    = crc_ok_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d   = RX_DATA;
                    bit_cnt_d = '0;
                    crc_d     = '0;
                end
            end
            RX_DATA: begin
                shift_d   = {shift_q[PKT_W-2:0], rx_s};
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                // The trailing CRC field itself is not folded into the CRC.
                if (bit_cnt_q < DATA_BITS) begin
                    crc_d = crc8_step(crc_q, rx_s);
                end
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_s) begin
                    rx_packet_d = shift_q;
                    crc_ok_d    = (crc_q == shift_q[CRC_W-1:0]);
                    rx_valid_d  = 1'b1;
                    state_d     = RX_IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = RX_WAIT_IDLE;
                end
            end
            RX_WAIT_IDLE: begin
                // A broken frame may leave the line low; only a return to idle re-arms.
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RX_IDLE;
            bit_cnt_q   <= '0;
            crc_q       <= '0;
            shift_q     <= '0;
            rx_packet_q <= '0;
            rx_valid_q  <= 1'b0;
            crc_ok_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            crc_q       <= crc_d;
            shift_q     <= shift_d;
            rx_packet_q <= rx_packet_d;
            rx_valid_q  <= rx_valid_d;
            crc_ok_q    <= crc_ok_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_packet = rx_packet_q;
    assign rx_valid  = rx_valid_q;
    assign crc_ok    = crc_ok_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != RX_IDLE);

`ifdef RX_ERR_COUNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if ((frame_err_d || (rx_valid_d && !crc_ok_d)) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule
